// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256/224 constants, FSM states and round functions
// shared by the streaming engine and its message schedule.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_COMPRESS,
    ST_UPDATE,
    ST_OUT
  } state_e;

  typedef logic [0:7][31:0]  hash_t;
  typedef logic [15:0][31:0] blk_t;

  localparam hash_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hash_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched.sv
// sha256_sched: 16-word sliding-window message schedule; wt_o is
// W_t for the current round, the window advances once per round.
module sha256_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        shift_i,
  input  blk_t        blk_i,
  output logic [31:0] wt_o
);

  blk_t        win_q, win_d;
  logic [31:0] nxt;

  // W[t+16] from the window holding W[t]..W[t+15]
  assign nxt = ssig1(win_q[14]) + win_q[9]
             + ssig0(win_q[1]) + win_q[0];

  always_comb begin
    win_d = win_q;
    if (load_i)
      win_d = blk_i;
    else if (shift_i)
      win_d = {nxt, win_q[15:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      win_q <= '0;
    else
      win_q <= win_d;
  end

  assign wt_o = win_q[0];

endmodule

// File: rtl/sha256_stream.sv
// sha256_stream: streaming SHA-256/224 hasher with in-hardware
// padding, one round per cycle, valid/ready in and out.
module sha256_stream
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode_224,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);

  state_e             state_q, state_d;
  logic               rdy_en_q;
  blk_t               blk_q, blk_d, pblk;
  logic [4:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [63:0]        len64;
  logic               mode_q, mode_d;
  logic [6:0]         end_q, end_d;
  logic               ended_q, ended_d;
  logic               synth_q, synth_d;
  logic               padded_q, padded_d;
  logic               extra_q, extra_d;
  hash_t              h_q, h_d, wv_q, wv_d;
  logic [5:0]         t_q, t_d;
  logic               ov_q, ov_d;
  logic [255:0]       dig_q, dig_d;
  logic               acc;
  logic [2:0]         nb;
  logic [31:0]        wt, t1, t2;

  assign in_ready = rdy_en_q &&
    (state_q == ST_IDLE ||
     (state_q == ST_LOAD && idx_q < 5'd16));
  assign acc   = in_valid && in_ready;
  assign nb    = (in_last && in_nbytes < 3'd4) ? in_nbytes : 3'd4;
  assign len64 = 64'(len_q);

  // Padded view of the buffer: fed straight into the schedule in PAD
  always_comb begin
    pblk = blk_q;
    if (synth_q || ended_q) begin
      for (int w = 0; w < 16; w++) begin
        for (int y = 0; y < 4; y++) begin
          if (synth_q)
            pblk[w][31-8*y -: 8] =
              (w == 0 && y == 0 && !padded_q) ? 8'h80 : 8'h00;
          else if (7'(4*w+y) == end_q)
            pblk[w][31-8*y -: 8] = 8'h80;
          else if (7'(4*w+y) > end_q)
            pblk[w][31-8*y -: 8] = 8'h00;
        end
      end
      if (synth_q || end_q <= 7'd55) begin
        pblk[14] = len64[63:32];
        pblk[15] = len64[31:0];
      end
    end
  end

  sha256_sched u_sched (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == ST_PAD),
    .shift_i (state_q == ST_COMPRESS),
    .blk_i   (pblk),
    .wt_o    (wt)
  );

  assign t1 = wv_q[7] + bsig1(wv_q[4])
            + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q] + wt;
  assign t2 = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    idx_d    = idx_q;
    len_d    = len_q;
    mode_d   = mode_q;
    end_d    = end_q;
    ended_d  = ended_q;
    synth_d  = synth_q;
    padded_d = padded_q;
    extra_d  = extra_q;
    h_d      = h_q;
    wv_d     = wv_q;
    t_d      = t_q;
    ov_d     = ov_q;
    dig_d    = dig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          h_d      = mode_224 ? IV224 : IV256;
          mode_d   = mode_224;
          len_d    = LEN_W'({nb, 3'b000});
          blk_d[0] = in_data;
          idx_d    = 5'd1;
          ended_d  = in_last;
          end_d    = 7'(nb);
          synth_d  = 1'b0;
          padded_d = 1'b0;
          extra_d  = 1'b0;
          state_d  = in_last ? ST_PAD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (acc) begin
          blk_d[idx_q[3:0]] = in_data;
          idx_d = idx_q + 5'd1;
          len_d = len_q + LEN_W'({nb, 3'b000});
          if (in_last) begin
            ended_d = 1'b1;
            end_d = 7'({idx_q[3:0], 2'b00}) + 7'(nb);
          end
          if (in_last || idx_q == 5'd15)
            state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        wv_d = h_q;
        t_d  = 6'd0;
        if (synth_q) begin
          padded_d = 1'b1;
          extra_d  = 1'b0;
        end else if (ended_q) begin
          padded_d = end_q < 7'd64;
          extra_d  = end_q > 7'd55;
        end
        state_d = ST_COMPRESS;
      end
      ST_COMPRESS: begin
        wv_d = {t1 + t2, wv_q[0], wv_q[1], wv_q[2],
                wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
        t_d = t_q + 6'd1;
        if (t_q == 6'd63)
          state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        for (int i = 0; i < 8; i++)
          h_d[i] = h_q[i] + wv_q[i];
        if (!ended_q) begin
          idx_d   = 5'd0;
          state_d = ST_LOAD;
        end else if (extra_q) begin
          synth_d = 1'b1;
          state_d = ST_PAD;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (!ov_q) begin
          ov_d  = 1'b1;
          dig_d = mode_q ? {h_q[0:6], 32'h0} : h_q;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      blk_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      end_q    <= '0;
      ended_q  <= 1'b0;
      synth_q  <= 1'b0;
      padded_q <= 1'b0;
      extra_q  <= 1'b0;
      h_q      <= '0;
      wv_q     <= '0;
      t_q      <= '0;
      ov_q     <= 1'b0;
      dig_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      end_q    <= end_d;
      ended_q  <= ended_d;
      synth_q  <= synth_d;
      padded_q <= padded_d;
      extra_q  <= extra_d;
      h_q      <= h_d;
      wv_q     <= wv_d;
      t_q      <= t_d;
      ov_q     <= ov_d;
      dig_q    <= dig_d;
    end
  end

  assign out_valid = ov_q;
  assign digest    = dig_q;

endmodule

// File: tb/tb_sha256_stream.sv
// tb_sha256_stream: directed vectors for sha256_stream with a
// scoreboard queue checked by an independent output monitor.
module tb_sha256_stream;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mode_224 = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] digest;

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_224 =
    256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

  typedef struct {
    logic [255:0] d;
    int           at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        ov_prev = 1'b0;
  logic [31:0] msg [16];
  int          nw = 0;
  logic [2:0]  lastnb = '0;

  sha256_stream #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_224  (mode_224),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every rising out_valid consumes one expectation
  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("digest", digest, mon_e.d);
          if (mon_e.at >= 0)
            chk("out_latency", 256'(cyc), 256'(mon_e.at));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic load_abc();
    msg[0] = 32'h61626300;
    nw = 1;
    lastnb = 3'd3;
  endtask

  task automatic load_empty();
    msg[0] = 32'h00000000;
    nw = 1;
    lastnb = 3'd0;
  endtask

  task automatic load_56();
    msg[0]  = 32'h61626364; msg[1]  = 32'h62636465;
    msg[2]  = 32'h63646566; msg[3]  = 32'h64656667;
    msg[4]  = 32'h65666768; msg[5]  = 32'h66676869;
    msg[6]  = 32'h6768696a; msg[7]  = 32'h68696a6b;
    msg[8]  = 32'h696a6b6c; msg[9]  = 32'h6a6b6c6d;
    msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
    msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071;
    nw = 14;
    lastnb = 3'd4;
  endtask

  // Called at a negedge; returns at a negedge
  task automatic send_msg(input logic m, input bit gaps,
                          input int lat, input logic [255:0] d,
                          input bit push);
    int   hs;
    int   w;
    int   g;
    exp_t e;
    hs = 0;
    mode_224 = m;
    for (int i = 0; i < nw; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) @(negedge clk);
      end
      in_data   = msg[i];
      in_last   = (i == nw - 1);
      in_nbytes = (i == nw - 1) ? lastnb : 3'd4;
      in_valid  = 1'b1;
      w = 0;
      while (!in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300)
        chk("in_ready_timeout", 0, 1);
      hs = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (push) begin
      e.d  = d;
      e.at = (lat < 0) ? -1 : hs + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000)
      chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 0);
    chk("rst_out_valid", 256'(out_valid), 0);
    chk("rst_digest", digest, 0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready_low", 256'(in_ready), 0);
    @(negedge clk);
    chk("rel_in_ready_high", 256'(in_ready), 1);

    load_abc();
    send_msg(1'b0, 1'b0, 67, D_ABC, 1'b1);
    wait_done();

    load_empty();
    send_msg(1'b0, 1'b0, 67, D_EMPTY, 1'b1);
    wait_done();

    load_56();
    send_msg(1'b0, 1'b0, 133, D_56, 1'b1);
    wait_done();

    load_abc();
    send_msg(1'b1, 1'b0, 67, D_224, 1'b1);
    wait_done();

    // Backpressure: digest held while out_ready is low
    out_ready = 1'b0;
    load_abc();
    send_msg(1'b0, 1'b0, 67, D_ABC, 1'b1);
    w = 0;
    while (!out_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300)
      chk("bp_timeout", 0, 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 256'(out_valid), 1);
      chk("bp_digest", digest, D_ABC);
      chk("bp_in_ready", 256'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_out_valid", 256'(out_valid), 0);
    chk("post_hs_in_ready", 256'(in_ready), 1);
    wait_done();

    load_56();
    send_msg(1'b0, 1'b1, 133, D_56, 1'b1);
    wait_done();

    // Abort a message mid-compression
    load_abc();
    send_msg(1'b0, 1'b0, -1, D_ABC, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_in_ready", 256'(in_ready), 0);
    chk("abort_rst_out_valid", 256'(out_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 256'(out_valid), 0);
    chk("abort_in_ready", 256'(in_ready), 1);
    repeat (80) @(negedge clk);
    chk("abort_no_out", 256'(out_valid), 0);

    load_abc();
    send_msg(1'b0, 1'b0, 67, D_ABC, 1'b1);
    wait_done();

    chk("sb_drained", 256'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
